// File: rtl/snake_arbiter.sv
// snake_arbiter: game-rule block for the two-snake game.
//   Divides clk into the selectable game tick clk_game, flags collisions for
//   each snake, and owns both food positions and both scores (eat detection,
//   saturating score increment, relocation of eaten food to a free cell).
// Ports:
//   clk          in   system clock, all state on rising edge
//   rst          in   asynchronous active-high reset
//   clk_rate     in   2-bit tick speed, 00 fastest .. 11 slowest
//   snake1/2     in   MAX_LEN segments of NUM_LEN bits, segment 0 = head
//   clk_game     out  divided game clock (square wave)
//   should_stop1 out  snake 1 collided (registered, not sticky)
//   should_stop2 out  snake 2 collided (registered, not sticky)
//   food1/food2  out  food positions {y, x}
//   score1/2     out  scores, equal to each snake's valid length
module snake_arbiter #(
    parameter int MAX_LEN = 16,
    parameter int NUM_LEN = 10,
    parameter int MAX_LEN_BIT_LEN = 4,
    parameter int WIDTH = 32,
    parameter int HEIGHT = 24,
    parameter int CLK_DIV_NUM = 12500000,
    parameter logic [NUM_LEN-1:0] INIT_FOOD1 = 10'h003,
    parameter logic [NUM_LEN-1:0] INIT_FOOD2 = 10'h0A3,
    parameter logic [MAX_LEN_BIT_LEN-1:0] INIT_SCORE = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 clk_rate,
    input  logic [MAX_LEN*NUM_LEN-1:0] snake1,
    input  logic [MAX_LEN*NUM_LEN-1:0] snake2,
    output logic                       clk_game,
    output logic                       should_stop1,
    output logic                       should_stop2,
    output logic [NUM_LEN-1:0]         food1,
    output logic [NUM_LEN-1:0]         food2,
    output logic [MAX_LEN_BIT_LEN-1:0] score1,
    output logic [MAX_LEN_BIT_LEN-1:0] score2
);
    localparam int XB = NUM_LEN / 2;
    localparam logic [NUM_LEN-1:0] EMPTY = '1;

    logic [31:0] cnt;
    logic [31:0] limit;
    logic prev_game;
    logic tick;
    logic [15:0] lfsr;
    logic pend1;
    logic pend2;
    logic [NUM_LEN-1:0] head1;
    logic [NUM_LEN-1:0] head2;
    logic [NUM_LEN-1:0] cand;
    logic cand_free;
    logic valid1;
    logic valid2;
    logic stop1_n;
    logic stop2_n;

    // True when p matches a non-empty segment of s with first <= index < len.
    function automatic logic on_snake(
        input logic [NUM_LEN-1:0] p,
        input logic [MAX_LEN*NUM_LEN-1:0] s,
        input logic [MAX_LEN_BIT_LEN-1:0] len,
        input int first
    );
        on_snake = 1'b0;
        for (int i = 0; i < MAX_LEN; i++)
            if (i >= first && i < int'(len) && s[i*NUM_LEN +: NUM_LEN] == p && s[i*NUM_LEN +: NUM_LEN] != EMPTY)
                on_snake = 1'b1;
    endfunction

    assign limit = 32'(CLK_DIV_NUM) << clk_rate;
    assign tick  = clk_game & ~prev_game;
    assign head1 = snake1[0 +: NUM_LEN];
    assign head2 = snake2[0 +: NUM_LEN];
    assign cand  = lfsr[NUM_LEN-1:0];

    always_comb begin
        stop1_n   = on_snake(head1, snake1, score1, 1) | on_snake(head1, snake2, score2, 0);
        stop2_n   = on_snake(head2, snake2, score2, 1) | on_snake(head2, snake1, score1, 0);
        cand_free = int'(cand[NUM_LEN-1:XB]) < HEIGHT && int'(cand[XB-1:0]) < WIDTH &&
                    !on_snake(cand, snake1, score1, 0) && !on_snake(cand, snake2, score2, 0);
        valid1    = cand_free && cand != food2;
        valid2    = cand_free && cand != food1;
    end

    // The limit is re-evaluated every cycle, so a rate change that drops the
    // limit below the running count toggles on the very next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            clk_game  <= 1'b0;
            prev_game <= 1'b0;
            lfsr      <= 16'hACE1;
        end else begin
            cnt       <= (cnt >= limit - 1) ? '0 : cnt + 1;
            clk_game  <= (cnt >= limit - 1) ? ~clk_game : clk_game;
            prev_game <= clk_game;
            lfsr      <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    // Eating requires !pend, so a food awaiting relocation cannot be rescored.
    // Food 2 is relocated only while food 1 is settled, so the two never take
    // the same candidate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            should_stop1 <= 1'b0;
            should_stop2 <= 1'b0;
            score1       <= INIT_SCORE;
            score2       <= INIT_SCORE;
            food1        <= INIT_FOOD1;
            food2        <= INIT_FOOD2;
            pend1        <= 1'b0;
            pend2        <= 1'b0;
        end else begin
            should_stop1 <= stop1_n;
            should_stop2 <= stop2_n;
            if (tick && head1 == food1 && !pend1) begin
                pend1  <= 1'b1;
                score1 <= (score1 == '1) ? score1 : score1 + 1'b1;
            end else if (pend1 && valid1) begin
                food1 <= cand;
                pend1 <= 1'b0;
            end
            if (tick && head2 == food2 && !pend2) begin
                pend2  <= 1'b1;
                score2 <= (score2 == '1) ? score2 : score2 + 1'b1;
            end else if (pend2 && !pend1 && valid2) begin
                food2 <= cand;
                pend2 <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_snake_arbiter.sv
// tb_snake_arbiter: self-checking bench for snake_arbiter with a fast divider.
module tb_snake_arbiter;
    localparam int ML = 16;
    localparam int NL = 10;
    localparam int SB = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [1:0] clk_rate = 2'd0;
    logic [ML*NL-1:0] snake1 = '1;
    logic [ML*NL-1:0] snake2 = '1;
    logic clk_game;
    logic should_stop1;
    logic should_stop2;
    logic [NL-1:0] food1;
    logic [NL-1:0] food2;
    logic [SB-1:0] score1;
    logic [SB-1:0] score2;

    int pass_cnt = 0;
    int total_cnt = 0;
    int exp_q[$];
    int sc1 = 2;
    int sc2 = 2;

    always #5 clk = ~clk;

    snake_arbiter #(.CLK_DIV_NUM(4)) dut (
        .clk(clk), .rst(rst), .clk_rate(clk_rate),
        .snake1(snake1), .snake2(snake2),
        .clk_game(clk_game), .should_stop1(should_stop1), .should_stop2(should_stop2),
        .food1(food1), .food2(food2), .score1(score1), .score2(score2)
    );

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_game_low();
        int k;
        k = 0;
        while (clk_game !== 1'b0 && k < 100) begin
            cyc(1);
            k++;
        end
    endtask

    // Waits for one clk_game toggle, then counts clk cycles to the next one.
    task automatic measure(output int n);
        logic g;
        int k;
        g = clk_game;
        k = 0;
        while (clk_game === g && k < 200) begin
            cyc(1);
            k++;
        end
        g = clk_game;
        n = 0;
        while (clk_game === g && n < 200) begin
            cyc(1);
            n++;
        end
    endtask

    task automatic test_reset_init();
        logic [30:0] obs;
        rst = 1'b1;
        cyc(2);
        obs = {clk_game, should_stop1, should_stop2, score1, score2, food1, food2};
        total_cnt++;
        if (obs !== {3'b000, 4'd2, 4'd2, 10'h003, 10'h0A3})
            $display("FAIL reset_init got %h want %h", obs, {3'b000, 4'd2, 4'd2, 10'h003, 10'h0A3});
        else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_divider();
        int n;
        int e;
        logic g;
        clk_rate = 2'd0;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(4);
            measure(n);
            e = exp_q.pop_front();
            total_cnt++;
            if (n !== e) $display("FAIL div_rate0 got %0d want %0d", n, e);
            else pass_cnt++;
        end
        clk_rate = 2'd2;
        exp_q.push_back(16);
        measure(n);
        e = exp_q.pop_front();
        total_cnt++;
        if (n !== e) $display("FAIL div_rate2 got %0d want %0d", n, e);
        else pass_cnt++;
        clk_rate = 2'd3;
        exp_q.push_back(32);
        measure(n);
        e = exp_q.pop_front();
        total_cnt++;
        if (n !== e) $display("FAIL div_rate3 got %0d want %0d", n, e);
        else pass_cnt++;
        cyc(10);
        clk_rate = 2'd0;
        g = clk_game;
        cyc(1);
        total_cnt++;
        if (clk_game === g) $display("FAIL div_lower_toggle got %b want %b", clk_game, ~g);
        else pass_cnt++;
    endtask

    task automatic test_cross_collision();
        snake1 = '1;
        snake2 = '1;
        snake1[0 +: NL] = 10'h08E;
        snake2[NL +: NL] = 10'h08E;
        cyc(1);
        total_cnt++;
        if ({should_stop1, should_stop2} !== 2'b10)
            $display("FAIL cross_hit got %b want 10", {should_stop1, should_stop2});
        else pass_cnt++;
        snake2[NL +: NL] = 10'h3FF;
        cyc(1);
        total_cnt++;
        if ({should_stop1, should_stop2} !== 2'b00)
            $display("FAIL cross_empty got %b want 00", {should_stop1, should_stop2});
        else pass_cnt++;
        snake2[0 +: NL] = 10'h08E;
        cyc(1);
        total_cnt++;
        if ({should_stop1, should_stop2} !== 2'b11)
            $display("FAIL head_on got %b want 11", {should_stop1, should_stop2});
        else pass_cnt++;
        snake1 = '1;
        snake2 = '1;
        cyc(1);
    endtask

    task automatic test_self_eat();
        int k;
        int e;
        logic p1;
        logic p2;
        wait_game_low();
        snake1 = '1;
        snake2 = '1;
        snake1[0 +: NL] = 10'h003;
        snake1[NL +: NL] = 10'h004;
        snake1[2*NL +: NL] = 10'h003;
        cyc(1);
        total_cnt++;
        if (should_stop1 !== 1'b0) $display("FAIL self_masked got %b want 0", should_stop1);
        else pass_cnt++;
        sc1 = 3;
        exp_q.push_back(sc1);
        p1 = clk_game;
        p2 = clk_game;
        k = 0;
        while (score1 === 4'd2 && k < 100) begin
            p2 = p1;
            p1 = clk_game;
            cyc(1);
            k++;
        end
        e = exp_q.pop_front();
        total_cnt++;
        if (score1 !== SB'(e)) $display("FAIL eat_score got %0d want %0d", score1, e);
        else pass_cnt++;
        total_cnt++;
        if ({p2, p1} !== 2'b01) $display("FAIL eat_on_tick got %b want 01", {p2, p1});
        else pass_cnt++;
        cyc(1);
        total_cnt++;
        if (should_stop1 !== 1'b1) $display("FAIL self_unmasked got %b want 1", should_stop1);
        else pass_cnt++;
        k = 0;
        while (food1 === 10'h003 && k < 500) begin
            cyc(1);
            k++;
        end
        total_cnt++;
        if (food1 === 10'h003 || food1 === 10'h004 || food1[9:5] >= 5'd24 || food1 === food2)
            $display("FAIL eat_relocate got %h want free cell", food1);
        else pass_cnt++;
        snake1 = '1;
    endtask

    task automatic test_no_eat();
        logic [NL-1:0] f1;
        logic [NL-1:0] f2;
        snake1 = '1;
        snake2 = '1;
        f1 = food1;
        f2 = food2;
        cyc(30);
        total_cnt++;
        if (score1 !== SB'(sc1) || score2 !== SB'(sc2))
            $display("FAIL no_eat_score got %0d,%0d want %0d,%0d", score1, score2, sc1, sc2);
        else pass_cnt++;
        total_cnt++;
        if (food1 !== f1 || food2 !== f2)
            $display("FAIL no_eat_food got %h,%h want %h,%h", food1, food2, f1, f2);
        else pass_cnt++;
    endtask

    task automatic test_simul_eat();
        logic [NL-1:0] f1;
        logic [NL-1:0] f2;
        int k;
        int c1;
        int c2;
        int e1;
        int e2;
        wait_game_low();
        f1 = food1;
        f2 = food2;
        snake1 = '1;
        snake2 = '1;
        snake1[0 +: NL] = f1;
        snake2[0 +: NL] = f2;
        sc1++;
        sc2++;
        exp_q.push_back(sc1);
        exp_q.push_back(sc2);
        k = 0;
        while (score1 === SB'(sc1 - 1) && k < 100) begin
            cyc(1);
            k++;
        end
        e1 = exp_q.pop_front();
        e2 = exp_q.pop_front();
        total_cnt++;
        if (score1 !== SB'(e1) || score2 !== SB'(e2))
            $display("FAIL simul_score got %0d,%0d want %0d,%0d", score1, score2, e1, e2);
        else pass_cnt++;
        c1 = 0;
        c2 = 0;
        k = 0;
        while ((c1 == 0 || c2 == 0) && k < 1000) begin
            cyc(1);
            k++;
            if (c1 == 0 && food1 !== f1) c1 = k;
            if (c2 == 0 && food2 !== f2) c2 = k;
        end
        total_cnt++;
        if (c1 == 0 || c2 == 0 || c1 >= c2)
            $display("FAIL simul_order got c1=%0d c2=%0d want 0<c1<c2", c1, c2);
        else pass_cnt++;
        total_cnt++;
        if (food1 === food2 || food1 === f2 || food2 === f1 || food1[9:5] >= 5'd24 || food2[9:5] >= 5'd24)
            $display("FAIL simul_foods got %h,%h want distinct free cells", food1, food2);
        else pass_cnt++;
        snake1 = '1;
        snake2 = '1;
    endtask

    task automatic test_saturate();
        logic [NL-1:0] old;
        int k;
        int e;
        snake2 = '1;
        for (int it = 0; it < 13; it++) begin
            old = food1;
            snake1 = '1;
            snake1[0 +: NL] = old;
            sc1 = (sc1 == 15) ? 15 : sc1 + 1;
            exp_q.push_back(sc1);
            k = 0;
            while (food1 === old && k < 300) begin
                cyc(1);
                k++;
            end
            e = exp_q.pop_front();
            total_cnt++;
            if (score1 !== SB'(e) || food1 === old)
                $display("FAIL sat_eat%0d got score %0d food %h want score %0d new food", it, score1, food1, e);
            else pass_cnt++;
        end
        snake1 = '1;
    endtask

    task automatic test_reset_mid();
        logic [30:0] obs;
        int k;
        snake1 = '1;
        snake2 = '1;
        snake1[0 +: NL] = 10'h111;
        snake2[0 +: NL] = 10'h111;
        k = 0;
        while (clk_game !== 1'b1 && k < 100) begin
            cyc(1);
            k++;
        end
        #3;
        rst = 1'b1;
        #1;
        obs = {clk_game, should_stop1, should_stop2, score1, score2, food1, food2};
        total_cnt++;
        if (obs !== {3'b000, 4'd2, 4'd2, 10'h003, 10'h0A3})
            $display("FAIL reset_mid got %h want %h", obs, {3'b000, 4'd2, 4'd2, 10'h003, 10'h0A3});
        else pass_cnt++;
        cyc(2);
        rst = 1'b0;
        cyc(2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset_init();
        test_divider();
        test_cross_collision();
        test_self_eat();
        test_no_eat();
        test_simul_eat();
        test_saturate();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/snake_arbiter.md
Name: snake_arbiter

Overview:
- Game-rule block for the two-snake game.
- Divides the fast system clock into the selectable game tick `clk_game`.
- Flags collisions for each snake.
- Owns both food positions and both scores: detects eating on each game tick, increments scores and relocates eaten food to a pseudo-random free cell.
- Sits beside the snake movers; its registered outputs feed movement, display and game-over logic.

Parameters:
- MAX_LEN, 16, maximum segments per snake.
- NUM_LEN, 10, bits per position: {y[9:5], x[4:0]}; 10'h3FF marks an empty segment slot.
- MAX_LEN_BIT_LEN, 4, width of score/length.
- WIDTH, 32, valid x range 0..WIDTH-1.
- HEIGHT, 24, valid y range 0..HEIGHT-1.
- CLK_DIV_NUM, 12500000, base half-period of clk_game in clk cycles.
- INIT_FOOD1, 10'h003, reset position of food1.
- INIT_FOOD2, 10'h0A3, reset position of food2.
- INIT_SCORE, 2, reset value of both scores.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- clk_rate  input  2  tick speed: 00 fastest … 11 slowest.
- snake1  input  MAX_LEN*NUM_LEN  snake 1 segments; segment i = bits [i*NUM_LEN +: NUM_LEN], segment 0 = head.
- snake2  input  MAX_LEN*NUM_LEN  snake 2 segments, same packing.
- clk_game  output  1  divided game clock, square wave.
- should_stop1  output  1  snake 1 collided.
- should_stop2  output  1  snake 2 collided.
- food1  output  NUM_LEN  food 1 position.
- food2  output  NUM_LEN  food 2 position.
- score1  output  MAX_LEN_BIT_LEN  snake 1 score (= valid length).
- score2  output  MAX_LEN_BIT_LEN  snake 2 score (= valid length).

Behaviour:
- Reset (async, asserted at any time, including mid-count or mid-relocation):
  - Divider counter=0, clk_game=0.
  - should_stop1/2=0, score1/2=INIT_SCORE, food1=INIT_FOOD1, food2=INIT_FOOD2.
  - LFSR=16'hACE1; pending flags cleared.
- Clock divider:
  - Half-period limit = CLK_DIV_NUM << clk_rate.
  - Counter increments each clk. When counter >= limit-1: counter<=0 and clk_game toggles.
  - So clk_game high/low phases last CLK_DIV_NUM, 2x, 4x, 8x cycles for rate 00,01,10,11 (4/2/1/0.5 Hz at 100 MHz).
  - A clk_rate change takes effect on the next compare. Lowering the limit below the current count causes an immediate toggle.
- Tick detect: registered previous clk_game; tick = clk_game & ~prev, one clk cycle wide.
- Collision (registered every clk, latency 1 cycle, not sticky):
  - should_stop1 = head1 equals any snake1 segment i for 1 <= i < score1, OR equals any snake2 segment i for 0 <= i < score2.
  - Symmetric for should_stop2.
  - Segments equal to 10'h3FF never match.
  - Head-on (head1==head2): both flags set.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts every clk cycle.
  - Candidate = {lfsr[9:5], lfsr[4:0]}.
  - Candidate is valid when:
    - y < HEIGHT and x < WIDTH;
    - not equal to any valid segment (index < score) of either snake;
    - not equal to the other food.
- Eating: on a tick, if head1==food1, set pending1 and score1<=score1+1; same for snake 2.
  - Score saturates at 2^MAX_LEN_BIT_LEN-1 (15).
- Relocation: each clk with pending1 and a valid candidate: food1<=candidate, clear pending1.
  - Otherwise retry on following cycles; food1 holds its old value meanwhile.
  - Pending2 is served only on cycles when pending1 is clear, so both foods never receive the same candidate.
- A second tick arriving while pending does not rescore the same food, because scoring requires head==food and pending suppresses it.
- No tick: scores and foods hold.

Test Plan:
- Reset defaults: assert rst mid-run -> immediately clk_game=0, score1=score2=2, food1=10'h003, food2=10'h0A3, should_stop1/2=0.
- Divider (CLK_DIV_NUM=4): rate 00 -> clk_game toggles every 4 clk cycles; rate 10 -> every 16; switch to 11 -> every 32.
- Cross collision, score1=score2=2: snake1 head 10'h08E, snake2 segment1=10'h08E -> should_stop1=1 one cycle later, should_stop2=0. Set snake2 segment1 = 10'h3FF -> should_stop1=0.
- Self and length mask: snake1 segment2 equals head with score1=2 -> no stop; raise score1 to 3 -> should_stop1=1.
- Eat: snake1 head=10'h003 at a tick -> score1=3 on the tick cycle; within bounded cycles food1 changes to a cell with y<24, not on either snake, not equal to food2. No eat -> score and food unchanged across ticks.
- Simultaneous eat: heads on food1 and food2 at one tick -> both scores increment; food1 relocates first, then food2; final foods differ. Score at 15 stays 15 after eating.
